memory_read: RTL and testbench

- Read-side counterpart of the accelerator's load path.
- After a `start` pulse, sequentially reads back three regions and streams them out one byte per beat on a valid/ready interface:
  - the 4 byte-lane image banks,
  - the conv weight RAM,
  - the dense weight RAM.
- Used for host read-back and verification of loaded contents, and as the byte feeder for the compute engine.
- Sits between the on-chip M10K read ports and the consumer.

---
 rtl/memory_pkg.sv | 55 +++++
 rtl/rd_byte_fifo.sv | 63 ++++++
 rtl/memory_read.sv | 204 ++++++++++++++++++++
 tb/tb_memory_read.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
// Shared types, region codes and default sizes for the memory read-back path.
package memory_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_IMAGE,
        RD_CONV,
        RD_DENSE,
        DRAIN
    } read_state_t;

    localparam logic [1:0] REG_IMAGE = 2'd0;
    localparam logic [1:0] REG_CONV  = 2'd1;
    localparam logic [1:0] REG_DENSE = 2'd2;

    localparam int IMG_WORDS_DEFAULT   = 196;
    localparam int CONV_BYTES_DEFAULT  = 55744;
    localparam int DENSE_BYTES_DEFAULT = 37578;
    localparam int FIFO_DEPTH_DEFAULT  = 4;

    localparam int BEAT_W = 11;

    // One buffered output beat, packed as {last, region, data}.
    typedef struct packed {
        logic       last;
        logic [1:0] region;
        logic [7:0] data;
    } beat_t;

    // Describes the read issued last cycle, so the returning RAM byte can be routed.
    typedef struct packed {
        logic       valid;
        logic [1:0] region;
        logic [1:0] lane;
        logic       last;
    } rd_tag_t;

    function automatic logic [7:0] pick_lane(
        input logic [1:0] lane,
        input logic [7:0] b0,
        input logic [7:0] b1,
        input logic [7:0] b2,
        input logic [7:0] b3
    );
        logic [7:0] sel;
        case (lane)
            2'd0:    sel = b0;
            2'd1:    sel = b1;
            2'd2:    sel = b2;
            default: sel = b3;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/rd_byte_fifo.sv
// Small synchronous FIFO buffering {last, region, data} beats ahead of the consumer.
module rd_byte_fifo
    import memory_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEFAULT,
    parameter int WIDTH = BEAT_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign push_ok = push && (count_q != FULL);
    assign pop_ok  = pop && (count_q != '0);

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; an entry is only ever read after it has been written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/memory_read.sv
// Streams image banks, conv weights and dense weights out one byte per beat after start.
// Optional build macro MEMORY_READ_CHECKSUM_EN adds a running byte checksum output.
module memory_read
    import memory_pkg::*;
#(
    parameter int IMG_WORDS   = IMG_WORDS_DEFAULT,
    parameter int CONV_BYTES  = CONV_BYTES_DEFAULT,
    parameter int DENSE_BYTES = DENSE_BYTES_DEFAULT,
    parameter int FIFO_DEPTH  = FIFO_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [9:0]  image_ram_addr,
    input  logic [7:0]  q0,
    input  logic [7:0]  q1,
    input  logic [7:0]  q2,
    input  logic [7:0]  q3,
    output logic [15:0] conv_ram_addr,
    input  logic [7:0]  conv_q,
    output logic [15:0] dense_ram_addr,
    input  logic [7:0]  dense_q,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  out_region,
`ifdef MEMORY_READ_CHECKSUM_EN
    output logic [31:0] checksum,
`endif
    output logic        out_last
);

    localparam logic [9:0]  IMG_LAST   = 10'(IMG_WORDS - 1);
    localparam logic [15:0] CONV_LAST  = 16'(CONV_BYTES - 1);
    localparam logic [15:0] DENSE_LAST = 16'(DENSE_BYTES - 1);
    localparam int          CNT_W      = $clog2(FIFO_DEPTH) + 1;

    read_state_t state_q, state_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [9:0]  img_addr_q, img_addr_d;
    logic [1:0]  lane_q, lane_d;
    logic [15:0] conv_addr_q, conv_addr_d;
    logic [15:0] dense_addr_q, dense_addr_d;
    rd_tag_t     tag_q, tag_d;

    beat_t             push_beat, head_beat;
    logic              fifo_empty, fifo_pop, can_issue;
    logic [CNT_W-1:0]  fifo_count;

    // Leave one slot of headroom so the byte in flight always has a place to land.
    assign can_issue = (int'(fifo_count) + int'(tag_q.valid)) < (FIFO_DEPTH - 1);

    always_comb begin
        push_beat.last   = tag_q.last;
        push_beat.region = tag_q.region;
        case (tag_q.region)
            REG_IMAGE: push_beat.data = pick_lane(tag_q.lane, q0, q1, q2, q3);
            REG_CONV:  push_beat.data = conv_q;
            default:   push_beat.data = dense_q;
        endcase
    end

    rd_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BEAT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (tag_q.valid),
        .push_data (push_beat),
        .pop       (fifo_pop),
        .head      (head_beat),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign out_valid  = !fifo_empty;
    assign fifo_pop   = out_valid && out_ready;
    assign out_data   = out_valid ? head_beat.data   : 8'h00;
    assign out_region = out_valid ? head_beat.region : 2'd0;
    assign out_last   = out_valid && head_beat.last;

    always_comb begin
        // NOTE: every _d starts from its _q (or a safe constant) so no branch can infer a latch.
        state_d      = state_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        img_addr_d   = img_addr_q;
        lane_d       = lane_q;
        conv_addr_d  = conv_addr_q;
        dense_addr_d = dense_addr_q;
        tag_d        = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RD_IMAGE;
                    busy_d  = 1'b1;
                end
            end
            RD_IMAGE: begin
                if (can_issue) begin
                    tag_d  = '{valid: 1'b1, region: REG_IMAGE, lane: lane_q, last: 1'b0};
                    lane_d = lane_q + 2'd1;
                    if (lane_q == 2'd3) begin
                        if (img_addr_q == IMG_LAST) begin
                            img_addr_d = '0;
                            state_d    = RD_CONV;
                        end else begin
                            img_addr_d = img_addr_q + 10'd1;
                        end
                    end
                end
            end
            RD_CONV: begin
                if (can_issue) begin
                    tag_d = '{valid: 1'b1, region: REG_CONV, lane: 2'd0, last: 1'b0};
                    if (conv_addr_q == CONV_LAST) begin
                        conv_addr_d = '0;
                        state_d     = RD_DENSE;
                    end else begin
                        conv_addr_d = conv_addr_q + 16'd1;
                    end
                end
            end
            RD_DENSE: begin
                if (can_issue) begin
                    tag_d = '{valid: 1'b1, region: REG_DENSE, lane: 2'd0,
                              last: (dense_addr_q == DENSE_LAST)};
                    if (dense_addr_q == DENSE_LAST) begin
                        dense_addr_d = '0;
                        state_d      = DRAIN;
                    end else begin
                        dense_addr_d = dense_addr_q + 16'd1;
                    end
                end
            end
            DRAIN: begin
                if (fifo_empty && !tag_q.valid) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values of its peers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            img_addr_q   <= '0;
            lane_q       <= '0;
            conv_addr_q  <= '0;
            dense_addr_q <= '0;
            tag_q        <= '0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            img_addr_q   <= img_addr_d;
            lane_q       <= lane_d;
            conv_addr_q  <= conv_addr_d;
            dense_addr_q <= dense_addr_d;
            tag_q        <= tag_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign image_ram_addr = img_addr_q;
    assign conv_ram_addr  = conv_addr_q;
    assign dense_ram_addr = dense_addr_q;

`ifdef MEMORY_READ_CHECKSUM_EN
    logic [31:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (state_q == IDLE && start) begin
            checksum_d = '0;
        end else if (fifo_pop) begin
            checksum_d = checksum_q + 32'(head_beat.data);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_memory_read.sv
// Scoreboard bench for memory_read in a small configuration with randomized RAM contents.
module tb_memory_read;

    localparam int IMG_W   = 2;
    localparam int CONV_B  = 3;
    localparam int DENSE_B = 2;
    localparam int DEPTH   = 4;
    localparam int N_BEATS = 4 * IMG_W + CONV_B + DENSE_B;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        busy, done;
    logic [9:0]  image_ram_addr;
    logic [7:0]  q0, q1, q2, q3;
    logic [15:0] conv_ram_addr;
    logic [7:0]  conv_q;
    logic [15:0] dense_ram_addr;
    logic [7:0]  dense_q;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [1:0]  out_region;
    logic        out_last;
`ifdef MEMORY_READ_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    memory_read #(
        .IMG_WORDS   (IMG_W),
        .CONV_BYTES  (CONV_B),
        .DENSE_BYTES (DENSE_B),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .image_ram_addr (image_ram_addr),
        .q0             (q0),
        .q1             (q1),
        .q2             (q2),
        .q3             (q3),
        .conv_ram_addr  (conv_ram_addr),
        .conv_q         (conv_q),
        .dense_ram_addr (dense_ram_addr),
        .dense_q        (dense_q),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_region     (out_region),
`ifdef MEMORY_READ_CHECKSUM_EN
        .checksum       (checksum),
`endif
        .out_last       (out_last)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM models: contents per bank/address, 1-cycle read latency.
    logic [7:0] img_mem [4][IMG_W];
    logic [7:0] conv_mem [CONV_B];
    logic [7:0] dense_mem [DENSE_B];

    function automatic logic [7:0] img_rd(input int b, input logic [9:0] a);
        if (int'(a) < IMG_W) return img_mem[b][int'(a)];
        return 8'h00;
    endfunction

    always @(posedge clk) begin
        q0      <= img_rd(0, image_ram_addr);
        q1      <= img_rd(1, image_ram_addr);
        q2      <= img_rd(2, image_ram_addr);
        q3      <= img_rd(3, image_ram_addr);
        conv_q  <= (int'(conv_ram_addr) < CONV_B) ? conv_mem[int'(conv_ram_addr)] : 8'h00;
        dense_q <= (int'(dense_ram_addr) < DENSE_B) ? dense_mem[int'(dense_ram_addr)] : 8'h00;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard state: expected beats as {last, region, data}.
    logic [10:0] exp_q[$];
    logic [31:0] exp_sum;
    bit          ready_rand = 1'b0;
    bit          strict = 1'b0;
    int          t_base = 0;
    int          acc_base = 0;
    int          acc_total = 0;
    int          done_total = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops and compares on every accepted beat, checks stall stability.
    logic        prev_stall = 1'b0;
    logic [10:0] prev_beat = '0;
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (done) done_total++;
            if (prev_stall) begin
                check("valid_held", out_valid, 1);
                check("beat_stable", {out_last, out_region, out_data}, prev_beat);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat_queue_size", exp_q.size(), 1);
                end else begin
                    check("beat", {out_last, out_region, out_data}, exp_q.pop_front());
                end
                if (strict) check("beat_cycle", cyc, t_base + 3 + (acc_total - acc_base));
                acc_total++;
            end
            prev_stall = out_valid && !out_ready;
            prev_beat  = {out_last, out_region, out_data};
        end
    end

    task automatic fill_mem(input bit all_ff);
        exp_sum = '0;
        for (int b = 0; b < 4; b++)
            for (int a = 0; a < IMG_W; a++) begin
                img_mem[b][a] = all_ff ? 8'hFF : 8'($urandom);
                exp_sum += 32'(img_mem[b][a]);
            end
        for (int i = 0; i < CONV_B; i++) begin
            conv_mem[i] = all_ff ? 8'hFF : 8'($urandom);
            exp_sum += 32'(conv_mem[i]);
        end
        for (int i = 0; i < DENSE_B; i++) begin
            dense_mem[i] = all_ff ? 8'hFF : 8'($urandom);
            exp_sum += 32'(dense_mem[i]);
        end
    endtask

    // Reference order: per image address all four banks, then conv, then dense.
    task automatic push_expected();
        for (int a = 0; a < IMG_W; a++)
            for (int b = 0; b < 4; b++)
                exp_q.push_back({1'b0, 2'd0, img_mem[b][a]});
        for (int i = 0; i < CONV_B; i++)
            exp_q.push_back({1'b0, 2'd1, conv_mem[i]});
        for (int i = 0; i < DENSE_B; i++)
            exp_q.push_back({(i == DENSE_B - 1), 2'd2, dense_mem[i]});
    endtask

    task automatic run_pass(input bit rand_rdy, input bit restart, input bit all_ff);
        int d_base;
        fill_mem(all_ff);
        @(negedge clk);
        ready_rand = rand_rdy;
        strict     = !rand_rdy;
        acc_base   = acc_total;
        d_base     = done_total;
        t_base     = cyc;
        push_expected();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        if (restart) begin
            while (cyc < t_base + 5) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        for (int i = 0; i < 400 && done_total == d_base; i++) @(negedge clk);
        check("done_before_timeout", done_total > d_base, 1);
        repeat (5) @(negedge clk);
        check("done_once", done_total - d_base, 1);
        check("beats_in_pass", acc_total - acc_base, N_BEATS);
        check("queue_drained", exp_q.size(), 0);
        check("busy_after_done", busy, 0);
`ifdef MEMORY_READ_CHECKSUM_EN
        check("checksum", checksum, exp_sum);
`endif
        ready_rand = 1'b0;
        strict     = 1'b0;
    endtask

    task automatic reset_mid_pass();
        int d_base;
        fill_mem(1'b0);
        @(negedge clk);
        ready_rand = 1'b0;
        strict     = 1'b1;
        acc_base   = acc_total;
        d_base     = done_total;
        t_base     = cyc;
        push_expected();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Issues run one per cycle from t+1: conv byte 1 is issued in cycle t+10.
        while (cyc < t_base + 10) @(negedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_outputs", {out_valid, out_last, out_region, out_data, busy, done}, 0);
        check("rst_mid_addrs", {image_ram_addr, conv_ram_addr, dense_ram_addr}, 0);
`ifdef MEMORY_READ_CHECKSUM_EN
        check("rst_mid_checksum", checksum, 0);
`endif
        check("beats_before_reset", acc_total - acc_base, 4 * IMG_W);
        exp_q.delete();
        strict = 1'b0;
        reset  = 1'b0;
        repeat (4) @(negedge clk);
        check("no_done_after_reset", done_total - d_base, 0);
        check("fifo_flushed", out_valid, 0);
        check("idle_after_reset", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outputs", {out_valid, out_last, out_region, out_data, busy, done}, 0);
        check("reset_addrs", {image_ram_addr, conv_ram_addr, dense_ram_addr}, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_outputs", {out_valid, busy, done}, 0);

        run_pass(1'b0, 1'b0, 1'b0);
        repeat (3) run_pass(1'b1, 1'b0, 1'b0);
        run_pass(1'b0, 1'b1, 1'b0);
        reset_mid_pass();
        run_pass(1'b0, 1'b0, 1'b0);
        run_pass(1'b1, 1'b0, 1'b1);
        run_pass(1'b0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
